// File: rtl/trng_sample_ctrl_pkg.sv
// rtl/trng_sample_ctrl_pkg.sv - shared types and default constants for the TRNG sample controller
// Contents: trng_state_e FSM encoding, default parameter values.
package trng_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      SAMPLE = 3'd2,
      HOLD   = 3'd3,
      FAIL   = 3'd4
   } trng_state_e;

   localparam int TRNG_SETTLE_DEF = 16;
   localparam int TRNG_DIV_DEF    = 4;
   localparam int TRNG_REP_DEF    = 32;

endpackage

// File: rtl/trng_sample_ctrl_if.sv
// rtl/trng_sample_ctrl_if.sv - random byte valid/ready handshake bundle
// Signals: rnd_data[7:0] and rnd_valid (producer -> consumer), rnd_ready (consumer -> producer).
// Modports: master = byte producer (controller), slave = byte consumer.
interface trng_sample_ctrl_if;
   import trng_pkg::*;

   logic [7:0] rnd_data;
   logic       rnd_valid;
   logic       rnd_ready;

   modport master (output rnd_data, output rnd_valid, input rnd_ready);
   modport slave  (input rnd_data, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/trng_sample_ctrl_sync_2ff.sv
// rtl/trng_sample_ctrl_sync_2ff.sv - 1-bit two-flop synchronizer for asynchronous inputs
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized output).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/trng_sample_ctrl.sv
// rtl/trng_sample_ctrl.sv - ring-oscillator sampling, von Neumann debias, byte packing and health test
// Ports: clk, rst_n (async active-low), enable (run request), ro_out (async raw bit),
//        ro_activate (oscillator enable), rnd (byte handshake, master side),
//        busy (state not IDLE), health_fail (sticky stuck-source flag).
module trng_sample_ctrl
   import trng_pkg::*;
#(
   parameter int SETTLE_CYCLES = TRNG_SETTLE_DEF,
   parameter int SAMPLE_DIV    = TRNG_DIV_DEF,
   parameter int REP_LIMIT     = TRNG_REP_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  ro_out,
   output logic                  ro_activate,
   trng_sample_ctrl_if.master    rnd,
   output logic                  busy,
   output logic                  health_fail
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

   trng_state_e      state_q, state_d;
   logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             prev_q, prev_d;
   logic             phase_q, phase_d;   // 1 = first bit of the pair already captured
   logic             first_q, first_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             act_q, act_d;
   logic             fail_q, fail_d;

   logic             ro_s;
   logic             strobe;
   logic [REP_W-1:0] rep_next;
   logic             rep_hit;
   logic             emit;
   logic             byte_done;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (ro_out),
      .q_o   (ro_s)
   );

   // Strobe and health decode shared by the FSM and the datapath.
   always_comb begin
      strobe    = (state_q == SAMPLE) && (div_cnt_q == DIV_LAST);
      rep_next  = (ro_s == prev_q) ? rep_cnt_q + REP_W'(1) : REP_W'(1);
      rep_hit   = strobe && (rep_next >= REP_MAX);
      // A hit on the repetition limit swallows this strobe's pair result.
      emit      = strobe && !rep_hit && phase_q && (first_q != ro_s);
      byte_done = emit && (bit_cnt_q == 3'd7);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; dropping enable wins over every other transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (enable) state_d = SETTLE;
         SETTLE: begin
            if (!enable)                        state_d = IDLE;
            else if (settle_cnt_q == SET_LAST)  state_d = SAMPLE;
         end
         SAMPLE: begin
            if (!enable)        state_d = IDLE;
            else if (rep_hit)   state_d = FAIL;
            else if (byte_done) state_d = HOLD;
         end
         HOLD: begin
            if (!enable)                      state_d = IDLE;
            else if (valid_q && rnd.rnd_ready) state_d = SETTLE;
         end
         FAIL:   if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next-state logic
   always_comb begin
      settle_cnt_d = '0;
      div_cnt_d    = div_cnt_q;
      rep_cnt_d    = rep_cnt_q;
      prev_d       = prev_q;
      phase_d      = phase_q;
      first_d      = first_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      data_d       = data_q;

      // Registered outputs follow the state being entered.
      act_d   = (state_d == SETTLE) || (state_d == SAMPLE);
      valid_d = (state_d == HOLD);
      fail_d  = (state_d == FAIL);

      if (state_q == SETTLE) settle_cnt_d = settle_cnt_q + SET_W'(1);

      // Outside SAMPLE the sampling path is held clear, so every entry to
      // SETTLE/SAMPLE starts with fresh divider, pair phase, byte and health state.
      if (state_q != SAMPLE) begin
         div_cnt_d = '0;
         rep_cnt_d = '0;
         prev_d    = 1'b0;
         phase_d   = 1'b0;
         first_d   = 1'b0;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (strobe) begin
         div_cnt_d = '0;
         rep_cnt_d = rep_next;
         prev_d    = ro_s;
         if (!rep_hit) begin
            phase_d = !phase_q;
            if (!phase_q) begin
               first_d = ro_s;
            end else if (emit) begin
               // Pair 10 emits 1 and 01 emits 0: the emitted bit is the first bit.
               shift_d   = {shift_q[6:0], first_q};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (byte_done && enable) data_d = {shift_q[6:0], first_q};
            end
         end
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt_q <= '0;
         div_cnt_q    <= '0;
         rep_cnt_q    <= '0;
         prev_q       <= 1'b0;
         phase_q      <= 1'b0;
         first_q      <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         act_q        <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         settle_cnt_q <= settle_cnt_d;
         div_cnt_q    <= div_cnt_d;
         rep_cnt_q    <= rep_cnt_d;
         prev_q       <= prev_d;
         phase_q      <= phase_d;
         first_q      <= first_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         act_q        <= act_d;
         fail_q       <= fail_d;
      end
   end

   assign ro_activate   = act_q;
   assign rnd.rnd_data  = data_q;
   assign rnd.rnd_valid = valid_q;
   assign health_fail   = fail_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: doc/trng_sample_ctrl.md
# trng_sample_ctrl

Controller that sequences the ring-oscillator entropy source. It enables the oscillator, waits for it to settle and samples its synchronized output at a fixed divider rate. Samples are debiased with a von Neumann corrector and packed into bytes, which are offered on a valid/ready handshake. A repetition-count health test detects a stuck oscillator. It sits between the top-level pins (`ui_in` control, `uo_out` data) and the `ring_osc` instance, and drives that instance's `ro_activate`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 16: clock cycles `ro_activate` is high before the first sample (≥1).
- `SAMPLE_DIV`, default 4: clocks between raw samples (≥2).
- `REP_LIMIT`, default 32: count of consecutive identical raw samples that declares health failure (≥2).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request, level-sensitive.
- `ro_out` in 1: raw oscillator bit, asynchronous to `clk`.
- `ro_activate` out 1: oscillator enable, registered.
- `rnd_data` out 8: debiased random byte.
- `rnd_valid` out 1: `rnd_data` holds a complete byte.
- `rnd_ready` in 1: consumer accepts the byte.
- `busy` out 1: state is not IDLE.
- `health_fail` out 1: sticky stuck-source flag.

## Operation
- Reset values: all outputs 0; state IDLE; all counters and the shift register 0.
- `ro_out` passes through a 2-flop synchronizer. All sampling uses the synchronized bit `ro_s`.
- The FSM has five states: IDLE, SETTLE, SAMPLE, HOLD, FAIL.
- IDLE -> SETTLE when `enable` is 1. `ro_activate` is 1 in SETTLE and SAMPLE, and 0 in every other state.
- SETTLE -> SAMPLE after `SETTLE_CYCLES` cycles spent in SETTLE. The divider counter is cleared on entry to SAMPLE.
- SAMPLE:
  - A strobe fires every `SAMPLE_DIV` cycles; the first strobe is on the `SAMPLE_DIV`-th cycle in SAMPLE. Each strobe captures `ro_s` as one raw bit.
  - Raw bits are paired: first and second strobe, third and fourth, and so on.
  - Von Neumann rule: pair 01 emits 0, pair 10 emits 1, pairs 00 and 11 are discarded.
  - Emitted bits shift in MSB-first: `byte <= {byte[6:0], bit}`.
  - On the 8th emitted bit: state -> HOLD, `rnd_data` is loaded, `rnd_valid` = 1, and the oscillator stops.
- HOLD:
  - `rnd_data` and `rnd_valid` stay stable until `rnd_valid && rnd_ready`.
  - On that handshake cycle: `rnd_valid` -> 0, state -> SETTLE. The oscillator restarts with a full settle period, and the pair phase and bit count clear.
- Health test:
  - A repetition counter increments when a strobe sample equals the previous strobe sample; otherwise it resets to 1.
  - When it reaches `REP_LIMIT`: state -> FAIL and `health_fail` -> 1. That strobe's pair result is discarded.
  - FAIL is left only via `enable` = 0 (to IDLE, `health_fail` cleared) or via reset.
  - The repetition counter and previous sample clear on every entry to SETTLE.
- `enable` = 0 in SETTLE, SAMPLE or HOLD returns to IDLE on the next cycle:
  - the partial byte is discarded;
  - `rnd_valid` is forced to 0, even mid-HOLD (an abort is permitted to break the handshake);
  - `ro_activate` goes to 0.
- If an abort and a handshake fall in the same cycle, the abort wins: state -> IDLE, and the byte counts as consumed.
- The repetition-limit check takes priority over pair emission on the same strobe.

## Timing
- `ro_activate` rises 1 cycle after `enable` is sampled high in IDLE.
- The first strobe comes `SETTLE_CYCLES + SAMPLE_DIV` cycles after entry to SETTLE.
- Synchronizer latency is 2 cycles. The sample taken at a strobe reflects `ro_out` from at least 2 cycles earlier.
- Best case to the first byte is 16 strobes (all pairs emit); there is no upper bound.
- `rnd_valid` rises in the same cycle `rnd_data` updates (registered).
- Throughput: at most one byte per `SETTLE_CYCLES + 16·SAMPLE_DIV + 1` cycles.
- When `rst_n` is asserted asynchronously mid-operation, all outputs are 0 immediately.

## Structure
- Shared package `trng_pkg` holds:
  - the state enum `trng_state_e` (IDLE, SETTLE, SAMPLE, HOLD, FAIL);
  - default constants `TRNG_SETTLE_DEF`, `TRNG_DIV_DEF`, `TRNG_REP_DEF`.
- Sub-module `sync_2ff` is the 1-bit, 2-flop synchronizer with async active-low reset, reused for any other async pin.
- Counter widths are `$clog2` of the parameter values, plus 1 where needed.
- Top-level wiring connects `enable` to `ui_in[0]`, `rnd_data` to `uo_out`, `rnd_ready` to `ui_in[1]`, and `rnd_valid`, `health_fail` and `busy` to `uio_out[2:0]`.

## Test plan
All scenarios use default parameters.
- Reset: drive `rst_n` = 0 mid-SAMPLE -> all outputs 0 in the same cycle; IDLE after release.
- Debias: force the `ro_s` strobe sequence 0,1,1,0,0,0,1,1 then 0,1 ×6 -> the emitted bits are 0,1,0,0,0,0,0,0 and `rnd_data` = 0x40. `rnd_valid` rises on the strobe completing the 8th emitted bit.
- Handshake: hold `rnd_ready` = 0 for 10 cycles -> `rnd_data` and `rnd_valid` are stable and `ro_activate` = 0. When `rnd_ready` goes to 1, `rnd_valid` = 0 on the next cycle and `ro_activate` rises the same cycle.
- Health: tie `ro_out` = 1 -> `health_fail` = 1 at the 32nd strobe, `ro_activate` = 0, no `rnd_valid`. Then `enable` = 0 -> `health_fail` = 0 and IDLE.
- Abort: drop `enable` after 5 emitted bits -> IDLE the next cycle. Re-enable -> the first byte contains only post-restart bits.
- Timing: `enable` rises -> `ro_activate` is 1 after 1 cycle, and the first strobe comes 20 cycles after SETTLE entry.
